// File: rtl/mod_accum_if.sv
// Handshake bundle for the modular accumulator.
// Both sides use strict valid/ready: a transfer happens on a rising clock
// edge where valid and ready are both high; once valid is raised, the
// payload holds steady until that edge, and ready never depends
// combinationally on valid.
interface mod_accum_if #(
    parameter int W  = 7,
    parameter int KW = 8
);
    // Producer side: step value, load/accumulate select, handshake.
    logic [W-1:0]  __in0;
    logic          in_load;
    logic          in_valid;
    logic          in_ready;

    // Consumer side: reduced result, wrap count, handshake.
    logic [W-1:0]  __out0;
    logic [KW-1:0] out_wraps;
    logic          out_valid;
    logic          out_ready;

    // The accumulator itself.
    modport slave (
        input  __in0,
        input  in_load,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output __out0,
        output out_wraps,
        output out_valid
    );

    // The environment that drives steps and consumes results.
    modport master (
        output __in0,
        output in_load,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  __out0,
        input  out_wraps,
        input  out_valid
    );
endinterface

// File: rtl/mod_accum.sv
// Sequential modular accumulator: acc <- (acc + step) mod MOD, or
// acc <- step mod MOD in load mode. The reduction subtracts MOD once per
// cycle, so no divider is needed. The number of subtractions is reported
// with each result.
module mod_accum #(
    parameter int W    = 7,
    parameter int MOD  = 100,
    parameter int INIT = 0,
    parameter int KW   = 8
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active low
    mod_accum_if.slave  bus,
    output logic [1:0]  dbg_state   // current FSM state, for observation
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    // The modulus needs W+1 bits so that MOD = 2^W can be represented.
    localparam logic [W:0]    MOD_C  = (W+1)'(MOD);
    localparam logic [W-1:0]  INIT_C = W'(INIT);
    localparam logic [KW-1:0] K_MAX  = {KW{1'b1}};

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W:0]    sum_q, sum_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [KW-1:0] out_wraps_q, out_wraps_d;

    logic accept;
    logic sum_ge_mod;

    // A step is taken only in IDLE; in_ready is a pure state decode.
    assign accept     = (state_q == S_IDLE) && bus.in_valid;
    // sum is always W+1 bits, so this compare never overflows.
    assign sum_ge_mod = (sum_q >= MOD_C);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> REDUCE -> OUT -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                // Leave as soon as the remainder is in range.
                if (!sum_ge_mod) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: handshake flags come only from the state register.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_OUT);
        bus.__out0    = out_data_q;
        bus.out_wraps = out_wraps_q;
        dbg_state     = state_q;
    end

    // Datapath next values: load sum on accept, subtract MOD while too
    // large, then commit the remainder to acc and the output holding regs.
    always_comb begin
        acc_d       = acc_q;
        sum_d       = sum_q;
        k_d         = k_q;
        out_data_d  = out_data_q;
        out_wraps_d = out_wraps_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.in_load) begin
                        sum_d = {1'b0, bus.__in0};
                    end else begin
                        sum_d = {1'b0, acc_q} + {1'b0, bus.__in0};
                    end
                    k_d = '0;
                end
            end
            S_REDUCE: begin
                if (sum_ge_mod) begin
                    sum_d = sum_q - MOD_C;
                    // The wrap count saturates rather than rolling over.
                    if (k_q != K_MAX) begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    // sum < MOD <= 2^W, so the top bit is zero here.
                    acc_d       = sum_q[W-1:0];
                    out_data_d  = sum_q[W-1:0];
                    out_wraps_d = k_q;
                end
            end
            default: begin
                // OUT: everything holds while the consumer stalls.
            end
        endcase
    end

    // Datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= INIT_C;
            sum_q       <= '0;
            k_q         <= '0;
            out_data_q  <= INIT_C;
            out_wraps_q <= '0;
        end else begin
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_wraps_q <= out_wraps_d;
        end
    end

endmodule
